// File: rtl/spi_ram_arbiter_if.sv
// Both requester channels plus the SPI RAM command/response port.
// "slave" is the arbiter's view; "master" is the requesters-plus-RAM side.
interface spi_ram_arbiter_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic                 req0_we;
    logic [ADDR_SIZE-1:0] req0_addr;
    logic [ADDR_SIZE-1:0] req0_wdata;
    logic                 rsp0_valid;
    logic [ADDR_SIZE-1:0] rsp0_rdata;
    logic                 rsp0_err;

    logic                 req1_valid;
    logic                 req1_ready;
    logic                 req1_we;
    logic [ADDR_SIZE-1:0] req1_addr;
    logic [ADDR_SIZE-1:0] req1_wdata;
    logic                 rsp1_valid;
    logic [ADDR_SIZE-1:0] rsp1_rdata;
    logic                 rsp1_err;

    logic [ADDR_SIZE+1:0] ram_din;
    logic                 ram_rx_valid;
    logic [ADDR_SIZE-1:0] ram_dout;
    logic                 ram_tx_valid;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output ram_din, ram_rx_valid,
        input  ram_dout, ram_tx_valid
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  ram_din, ram_rx_valid,
        output ram_dout, ram_tx_valid
    );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter that serialises two requesters onto the SPI RAM's single
// command port and routes each read-data/write-ack response back to its owner.
module spi_ram_arbiter #(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_ram_arbiter_if.slave bus,
    output logic             busy
);
    localparam int            CW      = $clog2(RD_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CMD_ADDR, CMD_DATA, WAIT_RD, RESP} state_e;

    state_e               state_q, state_d;
    logic                 lastGrant_q;
    logic                 we_q;
    logic [ADDR_SIZE-1:0] wdata_q;
    logic [CW-1:0]        timeoutCnt_q, timeoutCnt_d;
    logic [ADDR_SIZE+1:0] ramDin_q, ramDin_d;
    logic                 ramRxValid_q;
    logic                 rsp0Valid_q, rsp1Valid_q;
    logic                 rsp0Err_q, rsp1Err_q;
    logic [ADDR_SIZE-1:0] rsp0Rdata_q, rsp1Rdata_q;

    logic                 grantSel, ready0, ready1, handshake;
    logic                 selWe;
    logic [ADDR_SIZE-1:0] selAddr, selWdata;
    logic [ADDR_SIZE-1:0] rspRdata_d;
    logic                 rspErr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (handshake) state_d = CMD_ADDR;
            CMD_ADDR: state_d = CMD_DATA;
            CMD_DATA: state_d = we_q ? RESP : WAIT_RD;
            WAIT_RD:  if (bus.ram_tx_valid || (timeoutCnt_q == TO_LAST)) state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Registered RAM/response outputs are loaded from state_d so they line up with the state they belong to.
    always_comb begin
        grantSel = 1'b0;
        if (bus.req0_valid && bus.req1_valid) grantSel = ~lastGrant_q;
        else if (bus.req1_valid)              grantSel = 1'b1;

        ready0    = (state_q == IDLE) && bus.req0_valid && !grantSel;
        ready1    = (state_q == IDLE) && bus.req1_valid && grantSel;
        handshake = ready0 || ready1;
        busy      = (state_q != IDLE);

        selWe    = grantSel ? bus.req1_we    : bus.req0_we;
        selAddr  = grantSel ? bus.req1_addr  : bus.req0_addr;
        selWdata = grantSel ? bus.req1_wdata : bus.req0_wdata;

        ramDin_d = ramDin_q;
        if (state_d == CMD_ADDR)      ramDin_d = {selWe ? 2'b00 : 2'b10, selAddr};
        else if (state_d == CMD_DATA) ramDin_d = we_q ? {2'b01, wdata_q} : {2'b11, {ADDR_SIZE{1'b0}}};

        rspRdata_d   = ((state_q == WAIT_RD) && bus.ram_tx_valid) ? bus.ram_dout : '0;
        rspErr_d     = (state_q == WAIT_RD) && !bus.ram_tx_valid;
        timeoutCnt_d = (state_q == WAIT_RD) ? timeoutCnt_q + CW'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant_q  <= 1'b1;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            timeoutCnt_q <= '0;
            ramDin_q     <= '0;
            ramRxValid_q <= 1'b0;
            rsp0Valid_q  <= 1'b0;
            rsp1Valid_q  <= 1'b0;
            rsp0Err_q    <= 1'b0;
            rsp1Err_q    <= 1'b0;
            rsp0Rdata_q  <= '0;
            rsp1Rdata_q  <= '0;
        end else begin
            if (handshake) begin
                lastGrant_q <= grantSel;
                we_q        <= selWe;
                wdata_q     <= selWdata;
            end
            timeoutCnt_q <= timeoutCnt_d;
            ramRxValid_q <= (state_d == CMD_ADDR) || (state_d == CMD_DATA);
            ramDin_q     <= ramDin_d;
            rsp0Valid_q  <= (state_d == RESP) && !lastGrant_q;
            rsp1Valid_q  <= (state_d == RESP) && lastGrant_q;
            rsp0Rdata_q  <= ((state_d == RESP) && !lastGrant_q) ? rspRdata_d : '0;
            rsp1Rdata_q  <= ((state_d == RESP) && lastGrant_q) ? rspRdata_d : '0;
            rsp0Err_q    <= (state_d == RESP) && !lastGrant_q && rspErr_d;
            rsp1Err_q    <= (state_d == RESP) && lastGrant_q && rspErr_d;
        end
    end

    assign bus.req0_ready   = ready0;
    assign bus.req1_ready   = ready1;
    assign bus.ram_din      = ramDin_q;
    assign bus.ram_rx_valid = ramRxValid_q;
    assign bus.rsp0_valid   = rsp0Valid_q;
    assign bus.rsp1_valid   = rsp1Valid_q;
    assign bus.rsp0_rdata   = rsp0Rdata_q;
    assign bus.rsp1_rdata   = rsp1Rdata_q;
    assign bus.rsp0_err     = rsp0Err_q;
    assign bus.rsp1_err     = rsp1Err_q;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: a behavioural SPI RAM plus a transaction-level
// model (grant rule, fixed latencies, memory image) checked every cycle.
module tb_spi_ram_arbiter;
    localparam int AW         = 8;
    localparam int RD_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    always #5 clk = ~clk;

    spi_ram_arbiter_if #(.ADDR_SIZE(AW)) bus ();

    spi_ram_arbiter #(.ADDR_SIZE(AW), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    // Behavioural RAM: tx_valid is sticky, cleared by a read-address command.
    logic [AW-1:0] ramMem [256] = '{default: '0};
    logic [AW-1:0] ramAddr      = '0;
    logic [AW-1:0] ramDout      = '0;
    logic          ramTxValid   = 1'b0;
    bit            ramMute;

    assign bus.ram_dout     = ramDout;
    assign bus.ram_tx_valid = ramTxValid;

    always @(posedge clk) begin
        if (bus.ram_rx_valid) begin
            case (bus.ram_din[AW+1:AW])
                2'b00:   ramAddr <= bus.ram_din[AW-1:0];
                2'b01:   ramMem[ramAddr] <= bus.ram_din[AW-1:0];
                2'b10: begin
                    ramAddr    <= bus.ram_din[AW-1:0];
                    ramTxValid <= 1'b0;
                end
                default: begin
                    ramTxValid <= !ramMute;
                    ramDout    <= ramMem[ramAddr];
                end
            endcase
        end
    end

    int            total = 0;
    int            bad   = 0;
    int            cyc, freeAt, txnStart, pendDue;
    bit            lastG, pendValid, pendOwner, pendErr;
    logic [AW-1:0] pendRdata;
    logic [AW+1:0] expDin1, expDin2;
    logic [AW-1:0] refMem [256] = '{default: '0};
    bit            hasReq [2];
    bit            reqWe [2];
    logic [AW-1:0] reqAddr [2];
    logic [AW-1:0] reqWdata [2];
    bit            randEnable, keepBusy;
    logic [AW-1:0] seenRdata [2];
    bit            seenErr [2];
    int            grantLog [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [AW-1:0] pickAddr();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h12;
            default: return AW'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic applyStimulus();
        for (int n = 0; n < 2; n++) begin
            if (!hasReq[n] && (keepBusy || (randEnable && $urandom_range(0, 3) == 0))) begin
                hasReq[n]   = 1'b1;
                reqWe[n]    = 1'($urandom_range(0, 1));
                reqAddr[n]  = pickAddr();
                reqWdata[n] = AW'($urandom);
            end
        end
        if (randEnable && cyc >= freeAt) ramMute = ($urandom_range(0, 5) == 0);
        bus.req0_valid = hasReq[0];
        bus.req0_we    = reqWe[0];
        bus.req0_addr  = reqAddr[0];
        bus.req0_wdata = reqWdata[0];
        bus.req1_valid = hasReq[1];
        bus.req1_we    = reqWe[1];
        bus.req1_addr  = reqAddr[1];
        bus.req1_wdata = reqWdata[1];
    endtask

    // Expected behaviour comes from the grant rule and the fixed per-command latencies.
    task automatic checkCycle();
        bit expBusy, grant, granted;
        expBusy = (cyc < freeAt);
        granted = !expBusy && (hasReq[0] || hasReq[1]);
        grant   = (hasReq[0] && hasReq[1]) ? !lastG : hasReq[1];

        checkOutput("ready0", bus.req0_ready, granted && !grant);
        checkOutput("ready1", bus.req1_ready, granted && grant);
        checkOutput("busy", busy, expBusy);
        checkOutput("ramRxValid", bus.ram_rx_valid, (cyc == txnStart + 1) || (cyc == txnStart + 2));
        if (cyc == txnStart + 1) checkOutput("ramDinAddr", bus.ram_din, expDin1);
        if (cyc == txnStart + 2) checkOutput("ramDinData", bus.ram_din, expDin2);
        checkOutput("rsp0Valid", bus.rsp0_valid, pendValid && (pendDue == cyc) && !pendOwner);
        checkOutput("rsp1Valid", bus.rsp1_valid, pendValid && (pendDue == cyc) && pendOwner);
        if (pendValid && pendDue == cyc) begin
            if (!pendOwner) begin
                checkOutput("rsp0Rdata", bus.rsp0_rdata, pendRdata);
                checkOutput("rsp0Err", bus.rsp0_err, pendErr);
            end else begin
                checkOutput("rsp1Rdata", bus.rsp1_rdata, pendRdata);
                checkOutput("rsp1Err", bus.rsp1_err, pendErr);
            end
            pendValid = 1'b0;
        end

        if (bus.rsp0_valid) begin seenRdata[0] = bus.rsp0_rdata; seenErr[0] = bus.rsp0_err; end
        if (bus.rsp1_valid) begin seenRdata[1] = bus.rsp1_rdata; seenErr[1] = bus.rsp1_err; end
        if (bus.req0_ready) grantLog.push_back(0);
        if (bus.req1_ready) grantLog.push_back(1);

        if (granted) begin
            txnStart  = cyc;
            expDin1   = {reqWe[grant] ? 2'b00 : 2'b10, reqAddr[grant]};
            expDin2   = reqWe[grant] ? {2'b01, reqWdata[grant]} : {2'b11, AW'(0)};
            pendDue   = reqWe[grant] ? cyc + 3 : cyc + 3 + (ramMute ? RD_TIMEOUT : 1);
            pendOwner = grant;
            pendErr   = !reqWe[grant] && ramMute;
            pendRdata = (reqWe[grant] || ramMute) ? '0 : refMem[reqAddr[grant]];
            if (reqWe[grant]) refMem[reqAddr[grant]] = reqWdata[grant];
            pendValid     = 1'b1;
            freeAt        = pendDue + 1;
            lastG         = grant;
            hasReq[grant] = 1'b0;
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus();
            #1;
            checkCycle();
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic resetDut();
        rst_n          = 1'b0;
        hasReq[0]      = 1'b0;
        hasReq[1]      = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        cyc       = 0;
        freeAt    = 0;
        txnStart  = -10;
        lastG     = 1'b1;
        pendValid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        ramMute    = 1'b0;
        randEnable = 1'b0;
        keepBusy   = 1'b0;
        for (int n = 0; n < 2; n++) begin
            hasReq[n]   = 1'b0;
            reqWe[n]    = 1'b0;
            reqAddr[n]  = '0;
            reqWdata[n] = '0;
        end
        applyStimulus();
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rstRsp0Valid", bus.rsp0_valid, 1'b0);
        checkOutput("rstRsp0Rdata", bus.rsp0_rdata, 8'h00);
        checkOutput("rstRsp0Err", bus.rsp0_err, 1'b0);
        checkOutput("rstRsp1Valid", bus.rsp1_valid, 1'b0);
        checkOutput("rstRsp1Rdata", bus.rsp1_rdata, 8'h00);
        checkOutput("rstRsp1Err", bus.rsp1_err, 1'b0);
        checkOutput("rstRamDin", bus.ram_din, 10'h000);
        checkOutput("rstRamRxValid", bus.ram_rx_valid, 1'b0);
        checkOutput("rstBusy", busy, 1'b0);
        resetDut();

        hasReq[0] = 1'b1; reqWe[0] = 1'b1; reqAddr[0] = 8'h12; reqWdata[0] = 8'hA5;
        runCycles(6);

        seenRdata[1] = '0;
        hasReq[1] = 1'b1; reqWe[1] = 1'b0; reqAddr[1] = 8'h12;
        runCycles(7);
        checkOutput("dirReadA5", seenRdata[1], 8'hA5);

        ramMute = 1'b1;
        seenErr[0] = 1'b0; seenRdata[0] = 8'hEE;
        hasReq[0] = 1'b1; reqWe[0] = 1'b0; reqAddr[0] = 8'h12;
        runCycles(5 + RD_TIMEOUT);
        checkOutput("timeoutErr", seenErr[0], 1'b1);
        checkOutput("timeoutRdata", seenRdata[0], 8'h00);
        ramMute = 1'b0;

        hasReq[0] = 1'b1; reqWe[0] = 1'b0; reqAddr[0] = 8'h12;
        runCycles(2);
        #1;
        checkOutput("midRxBeforeRst", bus.ram_rx_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midRxAfterRst", bus.ram_rx_valid, 1'b0);
        checkOutput("midBusyAfterRst", busy, 1'b0);
        resetDut();
        runCycles(8);

        grantLog.delete();
        keepBusy = 1'b1;
        runCycles(40);
        keepBusy = 1'b0;
        runCycles(12);
        checkOutput("fairCount", grantLog.size() >= 8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i < grantLog.size()) checkOutput($sformatf("fairOrder%0d", i), grantLog[i], i % 2);
        end

        resetDut();
        seenRdata[1] = '0;
        hasReq[0] = 1'b1; reqWe[0] = 1'b1; reqAddr[0] = 8'hFF; reqWdata[0] = 8'h3C;
        hasReq[1] = 1'b1; reqWe[1] = 1'b0; reqAddr[1] = 8'hFF;
        runCycles(12);
        checkOutput("boundRead1", seenRdata[1], 8'h3C);
        seenRdata[0] = '0;
        hasReq[0] = 1'b1; reqWe[0] = 1'b0; reqAddr[0] = 8'hFF;
        hasReq[1] = 1'b1; reqWe[1] = 1'b1; reqAddr[1] = 8'hFF; reqWdata[1] = 8'hC3;
        runCycles(12);
        checkOutput("boundRead0First", seenRdata[0], 8'h3C);
        hasReq[0] = 1'b1; reqWe[0] = 1'b0; reqAddr[0] = 8'hFF;
        runCycles(7);
        checkOutput("boundRead0Second", seenRdata[0], 8'hC3);

        randEnable = 1'b1;
        runCycles(400);
        randEnable = 1'b0;
        runCycles(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
